tree_frame_encoder: RTL and testbench
=====================================

Name: tree_frame_encoder

Overview:
Packs one decision-tree node (id, feature, threshold, children, prediction) into the team's 95-bit tree frame. The frame layout is node[94:86], feature[85:84], threshold[83:20], left[19:11], right[10:2], pred[1:0]. The encoder serializes the frame MSB-first as a byte stream, optionally followed by an XOR checksum byte. It is the writer side of the tree-memory format: it feeds the host/UART loader that fills tree.mem-style node storage read back by the tree decoder.

Parameters:
DEPTH, 64, number of valid node slots; node_id >= DEPTH is rejected
EMIT_CHECKSUM, 1, 1 = append 13th byte (XOR of the 12 frame bytes); 0 = 12 bytes only

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  node fields valid
in_ready  out  1  encoder can accept a node
in_node  in  9  node id
in_feature  in  2  feature index
in_threshold  in  64  threshold
in_left  in  9  left child id
in_right  in  9  right child id
in_pred  in  2  leaf prediction
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts byte
out_data  out  8  serialized byte
out_last  out  1  marks final byte of frame (checksum byte if enabled)
err_node  out  1  one-cycle pulse: node rejected (in_node >= DEPTH)
frame_count  out  16  frames fully transmitted, wraps 0xFFFF->0

Behaviour:
- Clock is clk. Reset rst_n is asynchronous, active-low, and the one clock domain is clk.
- Reset values: in_ready=0 while rst_n low, then 1 (IDLE); out_valid=0; out_data=0; out_last=0; err_node=0; frame_count=0; shift register, byte counter and checksum all 0.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - SEND: out_valid=1, out_data=shift[95:88].
  - CSUM: out_valid=1, out_data=checksum, out_last=1.
- in_ready = (state==IDLE). There is no overlap between frames.
- Accept (in_valid & in_ready) with in_node < DEPTH:
  - latch W = {1'b0, in_node, in_feature, in_threshold, in_left, in_right, in_pred} (96 bits);
  - byte_cnt=0, checksum=0, go SEND.
  - First byte is valid on the next cycle (latency 1).
- Accept with in_node >= DEPTH: frame dropped, err_node=1 for exactly one cycle, stay IDLE.
- SEND handshake (out_valid & out_ready):
  - checksum ^= out_data; shift <<= 8; byte_cnt++.
  - On the 12th handshake (byte_cnt==11): go CSUM if EMIT_CHECKSUM, else go IDLE and frame_count++.
  - With EMIT_CHECKSUM=0, out_last=1 on byte 11.
- CSUM handshake: go IDLE, frame_count++.
- Backpressure: while out_valid & !out_ready, out_data and out_last are held stable and there is no state change. out_valid never drops without a handshake.
- Best-case throughput: 14 cycles/frame with checksum, 13 without (one IDLE cycle between frames).
- Reset asserted mid-frame: out_valid clears immediately (async). The partial frame is discarded and is not counted.
- Children/prediction are not range-checked; they are encoded verbatim.

Decomposition:
- Shared package tree_pkg:
  - field widths: NODE_W=9, FEAT_W=2, THR_W=64, PRED_W=2, FRAME_W=95;
  - field MSB/LSB bit-position constants;
  - BYTES_PER_FRAME=12;
  - the FSM state enum.
- The decoder side reuses the same field widths and bit positions.
- One natural sub-module: tree_frame_pack, a combinational field -> 95-bit frame packer, reusable by the memory-writer path. The FSM/serializer stays in the top module.

Test Plan:
- Basic encode, EMIT_CHECKSUM=1, out_ready=1: node=5, feature=2, threshold=100, left=6, right=7, pred=0.
  - Bytes: 01 60 00 00 00 00 00 00 06 40 30 1C, then 0B with out_last=1 on 0B.
  - frame_count becomes 1; first byte valid one cycle after accept.
- Backpressure: same frame, out_ready toggled 1-0-0-1 repeatedly.
  - Identical byte sequence; out_data stable during every stall; in_ready=0 until after last byte.
- Rejection: in_node=64 with DEPTH=64.
  - err_node high exactly 1 cycle, no out_valid, frame_count unchanged, in_ready stays 1.
- EMIT_CHECKSUM=0, all-ones fields (node=63, threshold=2^64-1, left=right=511, pred=3).
  - Bytes: 0F FF FF FF FF FF FF FF FF FF FF FF, with 12 bytes total and out_last on byte 12.
  - First byte is {0, node[8:2]} = 0x0F.
- Reset mid-frame: assert rst_n=0 after 5th byte handshake.
  - out_valid drops asynchronously; after release, in_ready=1, frame_count=0.
  - Next frame encodes correctly from byte 0.
- Back-to-back: 3 frames with in_valid held high.
  - Each accepted only in IDLE; frame_count=3; no byte lost or duplicated.

Source files
------------

// File: rtl/tree_pkg.sv
// Shared tree-frame definitions: field widths, bit positions and encoder FSM states.
package tree_pkg;

  localparam int unsigned NODE_W  = 9;
  localparam int unsigned FEAT_W  = 2;
  localparam int unsigned THR_W   = 64;
  localparam int unsigned PRED_W  = 2;
  localparam int unsigned FRAME_W = 95;

  localparam int unsigned NODE_MSB  = 94;
  localparam int unsigned NODE_LSB  = 86;
  localparam int unsigned FEAT_MSB  = 85;
  localparam int unsigned FEAT_LSB  = 84;
  localparam int unsigned THR_MSB   = 83;
  localparam int unsigned THR_LSB   = 20;
  localparam int unsigned LEFT_MSB  = 19;
  localparam int unsigned LEFT_LSB  = 11;
  localparam int unsigned RIGHT_MSB = 10;
  localparam int unsigned RIGHT_LSB = 2;
  localparam int unsigned PRED_MSB  = 1;
  localparam int unsigned PRED_LSB  = 0;

  localparam int unsigned BYTES_PER_FRAME = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CSUM = 2'd2
  } tx_state_t;

endpackage

// File: rtl/tree_frame_pack.sv
// Combinational packer: node fields -> 95-bit tree frame.
module tree_frame_pack
  import tree_pkg::*;
(
  input  logic [NODE_W-1:0]  node,
  input  logic [FEAT_W-1:0]  feature,
  input  logic [THR_W-1:0]   threshold,
  input  logic [NODE_W-1:0]  left,
  input  logic [NODE_W-1:0]  right,
  input  logic [PRED_W-1:0]  pred,
  output logic [FRAME_W-1:0] frame
);

  always_comb begin
    frame = '0;
    frame[NODE_MSB:NODE_LSB]   = node;
    frame[FEAT_MSB:FEAT_LSB]   = feature;
    frame[THR_MSB:THR_LSB]     = threshold;
    frame[LEFT_MSB:LEFT_LSB]   = left;
    frame[RIGHT_MSB:RIGHT_LSB] = right;
    frame[PRED_MSB:PRED_LSB]   = pred;
  end

endmodule

// File: rtl/tree_frame_encoder.sv
// Serializes one tree node as an MSB-first byte stream, optionally followed by an XOR checksum byte.
module tree_frame_encoder
  import tree_pkg::*;
#(
  parameter int unsigned DEPTH         = 64,
  parameter bit          EMIT_CHECKSUM = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NODE_W-1:0] in_node,
  input  logic [FEAT_W-1:0] in_feature,
  input  logic [THR_W-1:0]  in_threshold,
  input  logic [NODE_W-1:0] in_left,
  input  logic [NODE_W-1:0] in_right,
  input  logic [PRED_W-1:0] in_pred,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic              err_node,
  output logic [15:0]       frame_count
);

  tx_state_t        state, state_d;
  logic [95:0]      shift;
  logic [3:0]       byte_cnt;
  logic [7:0]       csum;
  logic [FRAME_W-1:0] frame;
  logic             accept, node_ok, last_byte, send_hs, frame_done;

  tree_frame_pack u_pack (
    .node      (in_node),
    .feature   (in_feature),
    .threshold (in_threshold),
    .left      (in_left),
    .right     (in_right),
    .pred      (in_pred),
    .frame     (frame)
  );

  // Gated by rst_n so the upstream sees no ready while reset is held.
  assign in_ready   = rst_n && (state == ST_IDLE);
  assign accept     = in_valid && in_ready;
  assign node_ok    = 32'(in_node) < DEPTH;
  assign last_byte  = (byte_cnt == 4'(BYTES_PER_FRAME - 1));
  assign send_hs    = (state == ST_SEND) && out_ready;
  assign frame_done = out_valid && out_ready && out_last;

  always_comb begin
    state_d   = state;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && node_ok) state_d = ST_SEND;
      end
      ST_SEND: begin
        out_valid = 1'b1;
        out_data  = shift[95:88];
        out_last  = !EMIT_CHECKSUM && last_byte;
        if (out_ready && last_byte) state_d = EMIT_CHECKSUM ? ST_CSUM : ST_IDLE;
      end
      ST_CSUM: begin
        out_valid = 1'b1;
        out_data  = csum;
        out_last  = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift       <= '0;
      byte_cnt    <= '0;
      csum        <= '0;
      err_node    <= 1'b0;
      frame_count <= '0;
    end else begin
      err_node <= accept && !node_ok;
      if (accept && node_ok) begin
        shift    <= {1'b0, frame};
        byte_cnt <= '0;
        csum     <= '0;
      end else if (send_hs) begin
        shift    <= {shift[87:0], 8'h00};
        byte_cnt <= byte_cnt + 4'd1;
        csum     <= csum ^ out_data;
      end
      if (frame_done) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_tree_frame_encoder.sv
// Directed self-checking bench for tree_frame_encoder (checksum and no-checksum instances).
module tb_tree_frame_encoder;

  logic        clk;
  logic        rst_n;
  logic        iv_a, iv_b, ordy;
  logic [8:0]  f_node, f_left, f_right;
  logic [1:0]  f_feat, f_pred;
  logic [63:0] f_thr;

  logic        in_ready_a, ov_a, olast_a, err_a;
  logic [7:0]  od_a;
  logic [15:0] fc_a;
  logic        in_ready_b, ov_b, olast_b, err_b;
  logic [7:0]  od_b;
  logic [15:0] fc_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_basic [13] = '{8'h01, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                 8'h00, 8'h06, 8'h40, 8'h30, 8'h1C, 8'h0B};
  logic [7:0] exp_ones  [12] = '{8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                                 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
  logic [3:0] bp_pat = 4'b1001;

  logic [7:0] cap_data [16];
  logic       cap_last [16];
  int         cap_n, stall_bad, ready_hi;
  bit         sent;

  tree_frame_encoder #(.DEPTH(64), .EMIT_CHECKSUM(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(in_ready_a),
    .in_node(f_node), .in_feature(f_feat), .in_threshold(f_thr),
    .in_left(f_left), .in_right(f_right), .in_pred(f_pred),
    .out_valid(ov_a), .out_ready(ordy), .out_data(od_a), .out_last(olast_a),
    .err_node(err_a), .frame_count(fc_a)
  );

  tree_frame_encoder #(.DEPTH(64), .EMIT_CHECKSUM(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(in_ready_b),
    .in_node(f_node), .in_feature(f_feat), .in_threshold(f_thr),
    .in_left(f_left), .in_right(f_right), .in_pred(f_pred),
    .out_valid(ov_b), .out_ready(ordy), .out_data(od_b), .out_last(olast_b),
    .err_node(err_b), .frame_count(fc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entered and left at posedge+1; offers one node and waits (bounded) for its accept edge.
  task automatic send(input bit sel, input logic [8:0] n, input logic [1:0] f,
                      input logic [63:0] t, input logic [8:0] l, input logic [8:0] r,
                      input logic [1:0] p);
    f_node = n; f_feat = f; f_thr = t; f_left = l; f_right = r; f_pred = p;
    if (sel) iv_b = 1'b1; else iv_a = 1'b1;
    sent = 1'b0;
    for (int unsigned k = 0; k < 20 && !sent; k++) begin
      #1;
      if (sel ? in_ready_b : in_ready_a) sent = 1'b1;
      @(posedge clk); #1;
    end
    iv_a = 1'b0;
    iv_b = 1'b0;
  endtask

  // Records handshaken bytes; bp selects the 1-0-0-1 out_ready pattern.
  task automatic capture(input bit sel, input int n, input bit bp);
    logic [7:0] held;
    logic       held_last, v, l;
    logic [7:0] d;
    bit         pend;
    int         cyc;
    cap_n = 0; stall_bad = 0; ready_hi = 0; pend = 1'b0; cyc = 0;
    for (int unsigned i = 0; i < 16; i++) begin
      cap_data[i] = 8'hxx;
      cap_last[i] = 1'bx;
    end
    while (cap_n < n && cyc < 400) begin
      ordy = bp ? bp_pat[cyc % 4] : 1'b1;
      #1;
      v = sel ? ov_b : ov_a;
      d = sel ? od_b : od_a;
      l = sel ? olast_b : olast_a;
      if (pend) begin
        if (!v || d !== held || l !== held_last) stall_bad++;
        pend = 1'b0;
      end
      if (sel ? in_ready_b : in_ready_a) ready_hi++;
      if (v && ordy) begin
        cap_data[cap_n] = d;
        cap_last[cap_n] = l;
        cap_n++;
      end else if (v) begin
        held = d; held_last = l; pend = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    ordy = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (in_ready_a !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready_a); end
    n_cmp++; if (ov_a !== 1'b0 || od_a !== 8'h00 || olast_a !== 1'b0) begin n_bad++; $display("FAIL reset_outputs: valid=%b data=%h last=%b want 0/00/0", ov_a, od_a, olast_a); end
    n_cmp++; if (err_a !== 1'b0 || fc_a !== 16'd0) begin n_bad++; $display("FAIL reset_err_count: err=%b count=%0d want 0/0", err_a, fc_a); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin n_bad++; $display("FAIL reset_idle_ready: got %b/%b want 1/1", in_ready_a, in_ready_b); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    send(1'b0, 9'd5, 2'd2, 64'd100, 9'd6, 9'd7, 2'd0);
    n_cmp++; if (!sent) begin n_bad++; $display("FAIL basic_accept: got no accept want accept"); end
    n_cmp++; if (ov_a !== 1'b1 || od_a !== 8'h01) begin n_bad++; $display("FAIL basic_latency: valid=%b data=%h want 1/01", ov_a, od_a); end
    capture(1'b0, 13, 1'b0);
    n_cmp++; if (cap_n !== 13) begin n_bad++; $display("FAIL basic_count: got %0d bytes want 13", cap_n); end
    for (int unsigned i = 0; i < 13; i++) begin
      n_cmp++;
      if (cap_data[i] !== exp_basic[i] || cap_last[i] !== (i == 12)) begin
        n_bad++; $display("FAIL basic_byte%0d: got %h last=%b want %h last=%b", i, cap_data[i], cap_last[i], exp_basic[i], (i == 12));
      end
    end
    n_cmp++; if (ov_a !== 1'b0 || in_ready_a !== 1'b1 || fc_a !== 16'd1) begin n_bad++; $display("FAIL basic_done: valid=%b ready=%b count=%0d want 0/1/1", ov_a, in_ready_a, fc_a); end
  endtask

  task automatic test_backpressure();
    send(1'b0, 9'd5, 2'd2, 64'd100, 9'd6, 9'd7, 2'd0);
    capture(1'b0, 13, 1'b1);
    n_cmp++; if (cap_n !== 13) begin n_bad++; $display("FAIL bp_count: got %0d bytes want 13", cap_n); end
    for (int unsigned i = 0; i < 13; i++) begin
      n_cmp++;
      if (cap_data[i] !== exp_basic[i] || cap_last[i] !== (i == 12)) begin
        n_bad++; $display("FAIL bp_byte%0d: got %h last=%b want %h last=%b", i, cap_data[i], cap_last[i], exp_basic[i], (i == 12));
      end
    end
    n_cmp++; if (stall_bad !== 0) begin n_bad++; $display("FAIL bp_stall_stable: got %0d unstable stalls want 0", stall_bad); end
    n_cmp++; if (ready_hi !== 0) begin n_bad++; $display("FAIL bp_in_ready_busy: got %0d ready cycles want 0", ready_hi); end
    n_cmp++; if (in_ready_a !== 1'b1 || fc_a !== 16'd2) begin n_bad++; $display("FAIL bp_done: ready=%b count=%0d want 1/2", in_ready_a, fc_a); end
  endtask

  task automatic test_reject();
    int errs;
    send(1'b0, 9'd64, 2'd1, 64'd5, 9'd1, 9'd2, 2'd1);
    n_cmp++; if (err_a !== 1'b1 || ov_a !== 1'b0) begin n_bad++; $display("FAIL reject_pulse: err=%b valid=%b want 1/0", err_a, ov_a); end
    errs = 1;
    for (int unsigned k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (err_a === 1'b1) errs++;
      if (ov_a !== 1'b0) errs += 100;
    end
    n_cmp++; if (errs !== 1) begin n_bad++; $display("FAIL reject_one_cycle: got %0d want 1", errs); end
    n_cmp++; if (in_ready_a !== 1'b1 || fc_a !== 16'd2) begin n_bad++; $display("FAIL reject_state: ready=%b count=%0d want 1/2", in_ready_a, fc_a); end
  endtask

  task automatic test_no_checksum();
    send(1'b1, 9'd63, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 9'd511, 9'd511, 2'd3);
    n_cmp++; if (ov_b !== 1'b1 || od_b !== 8'h0F) begin n_bad++; $display("FAIL nocs_first: valid=%b data=%h want 1/0F", ov_b, od_b); end
    capture(1'b1, 12, 1'b0);
    n_cmp++; if (cap_n !== 12) begin n_bad++; $display("FAIL nocs_count: got %0d bytes want 12", cap_n); end
    for (int unsigned i = 0; i < 12; i++) begin
      n_cmp++;
      if (cap_data[i] !== exp_ones[i] || cap_last[i] !== (i == 11)) begin
        n_bad++; $display("FAIL nocs_byte%0d: got %h last=%b want %h last=%b", i, cap_data[i], cap_last[i], exp_ones[i], (i == 11));
      end
    end
    n_cmp++; if (ov_b !== 1'b0 || fc_b !== 16'd1) begin n_bad++; $display("FAIL nocs_done: valid=%b count=%0d want 0/1", ov_b, fc_b); end
  endtask

  task automatic test_reset_mid();
    send(1'b0, 9'd5, 2'd2, 64'd100, 9'd6, 9'd7, 2'd0);
    capture(1'b0, 5, 1'b0);
    n_cmp++; if (ov_a !== 1'b1 || od_a !== 8'h00) begin n_bad++; $display("FAIL rmid_before: valid=%b data=%h want 1/00", ov_a, od_a); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (ov_a !== 1'b0 || in_ready_a !== 1'b0) begin n_bad++; $display("FAIL rmid_async_clear: valid=%b ready=%b want 0/0", ov_a, in_ready_a); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready_a !== 1'b1 || fc_a !== 16'd0) begin n_bad++; $display("FAIL rmid_after: ready=%b count=%0d want 1/0", in_ready_a, fc_a); end
    send(1'b0, 9'd5, 2'd2, 64'd100, 9'd6, 9'd7, 2'd0);
    capture(1'b0, 13, 1'b0);
    for (int unsigned i = 0; i < 13; i++) begin
      n_cmp++;
      if (cap_data[i] !== exp_basic[i] || cap_last[i] !== (i == 12)) begin
        n_bad++; $display("FAIL rmid_byte%0d: got %h last=%b want %h last=%b", i, cap_data[i], cap_last[i], exp_basic[i], (i == 12));
      end
    end
    n_cmp++; if (fc_a !== 16'd1) begin n_bad++; $display("FAIL rmid_count: got %0d want 1", fc_a); end
  endtask

  task automatic test_back_to_back();
    int acc, nb, cyc, overlap;
    f_node = 9'd5; f_feat = 2'd2; f_thr = 64'd100; f_left = 9'd6; f_right = 9'd7; f_pred = 2'd0;
    ordy = 1'b1; iv_a = 1'b1;
    acc = 0; nb = 0; cyc = 0; overlap = 0;
    while (nb < 39 && cyc < 200) begin
      #1;
      if (iv_a && in_ready_a) acc++;
      if (in_ready_a && ov_a) overlap++;
      if (ov_a) begin
        n_cmp++;
        if (od_a !== exp_basic[nb % 13] || olast_a !== ((nb % 13) == 12)) begin
          n_bad++; $display("FAIL b2b_byte%0d: got %h last=%b want %h last=%b", nb, od_a, olast_a, exp_basic[nb % 13], ((nb % 13) == 12));
        end
        nb++;
      end
      @(posedge clk); #1;
      if (acc == 3) iv_a = 1'b0;
      cyc++;
    end
    iv_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (acc !== 3 || nb !== 39) begin n_bad++; $display("FAIL b2b_totals: accepts=%0d bytes=%0d want 3/39", acc, nb); end
    n_cmp++; if (overlap !== 0) begin n_bad++; $display("FAIL b2b_overlap: got %0d want 0", overlap); end
    n_cmp++; if (fc_a !== 16'd4 || ov_a !== 1'b0) begin n_bad++; $display("FAIL b2b_count: count=%0d valid=%b want 4/0", fc_a, ov_a); end
  endtask

  initial begin
    rst_n = 1'b0; iv_a = 1'b0; iv_b = 1'b0; ordy = 1'b1;
    f_node = '0; f_feat = '0; f_thr = '0; f_left = '0; f_right = '0; f_pred = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reject();
    test_no_checksum();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
